csr_access_controller: RTL and testbench

//  Initiator side of the CSR access interface. Executes one Zicsr instruction
//  (CSRRW/S/C and the immediate forms): reads the old CSR value, computes the
//  new value, issues the write and waits for write_done.

---
 rtl/csr_access_controller.sv | 195 +++++++++++++++++++
 tb/tb_csr_access_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_controller.sv
// rtl/csr_access_controller.sv - Zicsr initiator: read old CSR, compute new value, write, await ack.
// Optional CSR_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module csr_access_controller
`ifdef CSR_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_index,
    input  logic [31:0] rs1_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_value,
    output logic        illegal,
    output logic [11:0] csr_addr_out,
    output logic [2:0]  csr_func3_out,
    output logic [4:0]  csr_imm_out,
    output logic [31:0] csr_wdata,
    output logic        csr_write_enable,
    input  logic        csr_write_done,
    input  logic [31:0] csr_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        we_q, we_d;
    logic [31:0] rd_value_q, rd_value_d;
    logic [31:0] wdata_q, wdata_d;
    logic [11:0] addr_q, addr_d;
    logic [2:0]  func3_q, func3_d;
    logic [4:0]  imm_q, imm_d;
    logic [31:0] rs1_data_q, rs1_data_d;

`ifdef CSR_TIMEOUT_EN
    localparam logic [4:0] WD_LAST = 5'(TIMEOUT_CYCLES - 1);
    logic [4:0] wd_q, wd_d;
`endif

    logic [31:0] op_src;
    logic [31:0] new_val;
    logic        do_write;

    always_comb begin
        op_src = func3_q[2] ? {27'b0, imm_q} : rs1_data_q;
        case (func3_q[1:0])
            2'b01:   new_val = op_src;
            2'b10:   new_val = csr_rdata | op_src;
            default: new_val = csr_rdata & ~op_src;
        endcase
        do_write = (func3_q[1:0] == 2'b01) || (imm_q != 5'd0);
    end

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        we_d       = 1'b0;
        rd_value_d = rd_value_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        func3_d    = func3_q;
        imm_d      = imm_q;
        rs1_data_d = rs1_data_q;
`ifdef CSR_TIMEOUT_EN
        wd_d       = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = csr_addr;
                    func3_d    = func3;
                    imm_d      = rs1_index;
                    rs1_data_d = rs1_data;
                    rd_value_d = 32'd0;
                    if (func3[1:0] == 2'b00) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                // csr_rdata is combinational on csr_addr_out, which is already latched here
                rd_value_d = csr_rdata;
                wdata_d    = new_val;
                if (!do_write) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (addr_q[11:10] == 2'b11) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    we_d    = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_WAIT;
`ifdef CSR_TIMEOUT_EN
                wd_d    = 5'd0;
`endif
            end
            ST_WAIT: begin
                if (csr_write_done) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
`ifdef CSR_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    wd_d = wd_q + 5'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            we_q       <= 1'b0;
            rd_value_q <= 32'd0;
            wdata_q    <= 32'd0;
            addr_q     <= 12'd0;
            func3_q    <= 3'd0;
            imm_q      <= 5'd0;
            rs1_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            we_q       <= we_d;
            rd_value_q <= rd_value_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            func3_q    <= func3_d;
            imm_q      <= imm_d;
            rs1_data_q <= rs1_data_d;
        end
    end

`ifdef CSR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= 5'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign busy             = busy_q;
    assign done             = done_q;
    assign illegal          = illegal_q;
    assign rd_value         = rd_value_q;
    assign csr_addr_out     = addr_q;
    assign csr_func3_out    = func3_q;
    assign csr_imm_out      = imm_q;
    assign csr_wdata        = wdata_q;
    assign csr_write_enable = we_q;

endmodule

// File: tb/tb_csr_access_controller.sv
// tb/tb_csr_access_controller.sv - directed self-checking bench for csr_access_controller.
module tb_csr_access_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  func3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_index;
    logic [31:0] rs1_data;
    logic        busy;
    logic        done;
    logic [31:0] rd_value;
    logic        illegal;
    logic [11:0] csr_addr_out;
    logic [2:0]  csr_func3_out;
    logic [4:0]  csr_imm_out;
    logic [31:0] csr_wdata;
    logic        csr_write_enable;
    logic        csr_write_done;
    logic [31:0] csr_rdata;

    logic [31:0] old_val;
    logic        ack;

    int checks = 0;
    int errors = 0;

    int          lat;
    int          wes;
    logic [31:0] wd_seen;
    logic        got_done;
    logic [31:0] done_rd;
    logic        done_ill;

    assign csr_rdata      = old_val;
    assign csr_write_done = ack;

    always #5 clk = ~clk;

    csr_access_controller dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .func3            (func3),
        .csr_addr         (csr_addr),
        .rs1_index        (rs1_index),
        .rs1_data         (rs1_data),
        .busy             (busy),
        .done             (done),
        .rd_value         (rd_value),
        .illegal          (illegal),
        .csr_addr_out     (csr_addr_out),
        .csr_func3_out    (csr_func3_out),
        .csr_imm_out      (csr_imm_out),
        .csr_wdata        (csr_wdata),
        .csr_write_enable (csr_write_enable),
        .csr_write_done   (csr_write_done),
        .csr_rdata        (csr_rdata)
    );

    // Latency counts clock edges from the start-sampling edge to the first cycle with done high.
    task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                          input logic [31:0] d, input int max_cyc);
        @(negedge clk);
        start = 1'b1; func3 = f3; csr_addr = a; rs1_index = idx; rs1_data = d;
        lat = 0; wes = 0; wd_seen = 32'd0; got_done = 1'b0; done_rd = 32'd0; done_ill = 1'b0;
        while (!got_done && lat < max_cyc) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (csr_write_enable) begin
                wes++;
                wd_seen = csr_wdata;
            end
            if (done) begin
                got_done = 1'b1;
                done_rd  = rd_value;
                done_ill = illegal;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; func3 = 3'd0; csr_addr = 12'd0; rs1_index = 5'd0;
        rs1_data = 32'd0; old_val = 32'd0; ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        checks++; if (csr_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", csr_write_enable); end
        checks++; if (rd_value !== 32'd0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd_value); end
        checks++; if (csr_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", csr_wdata); end
        checks++; if (csr_addr_out !== 12'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", csr_addr_out); end
        checks++; if (csr_func3_out !== 3'd0) begin errors++; $display("FAIL reset_func3 got=%h exp=0", csr_func3_out); end
        checks++; if (csr_imm_out !== 5'd0) begin errors++; $display("FAIL reset_imm got=%h exp=0", csr_imm_out); end
    endtask

    task automatic test_csrrw();
        old_val = 32'h1234_5678; ack = 1'b1;
        run_op(3'b001, 12'h340, 5'd5, 32'hDEAD_BEEF, 50);
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL rw_done got=%b exp=1", got_done); end
        checks++; if (lat != 4) begin errors++; $display("FAIL rw_latency got=%0d exp=4", lat); end
        checks++; if (wes != 1) begin errors++; $display("FAIL rw_we_count got=%0d exp=1", wes); end
        checks++; if (wd_seen !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_wdata got=%h exp=deadbeef", wd_seen); end
        checks++; if (done_rd !== 32'h1234_5678) begin errors++; $display("FAIL rw_rd got=%h exp=12345678", done_rd); end
        checks++; if (done_ill !== 1'b0) begin errors++; $display("FAIL rw_illegal got=%b exp=0", done_ill); end
        checks++; if (csr_addr_out !== 12'h340) begin errors++; $display("FAIL rw_addr_out got=%h exp=340", csr_addr_out); end
        checks++; if (csr_func3_out !== 3'b001) begin errors++; $display("FAIL rw_func3_out got=%h exp=1", csr_func3_out); end
        checks++; if (csr_imm_out !== 5'd5) begin errors++; $display("FAIL rw_imm_out got=%h exp=5", csr_imm_out); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_idle_busy got=%b exp=0", busy); end
        checks++; if (rd_value !== 32'h1234_5678) begin errors++; $display("FAIL rw_rd_held got=%h exp=12345678", rd_value); end
    endtask

    task automatic test_set_clear();
        old_val = 32'hA5A5_0001;
        run_op(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 50);
        checks++; if (lat != 2) begin errors++; $display("FAIL rs0_latency got=%0d exp=2", lat); end
        checks++; if (wes != 0) begin errors++; $display("FAIL rs0_we_count got=%0d exp=0", wes); end
        checks++; if (done_rd !== 32'hA5A5_0001) begin errors++; $display("FAIL rs0_rd got=%h exp=a5a50001", done_rd); end
        checks++; if (done_ill !== 1'b0) begin errors++; $display("FAIL rs0_illegal got=%b exp=0", done_ill); end
        old_val = 32'h0F00_000F;
        run_op(3'b010, 12'h300, 5'd3, 32'h0000_00F0, 50);
        checks++; if (lat != 4) begin errors++; $display("FAIL rs_latency got=%0d exp=4", lat); end
        checks++; if (wd_seen !== 32'h0F00_00FF) begin errors++; $display("FAIL rs_wdata got=%h exp=0f0000ff", wd_seen); end
        old_val = 32'hFFFF_00FF;
        run_op(3'b011, 12'h300, 5'd3, 32'h0000_0F0F, 50);
        checks++; if (wd_seen !== 32'hFFFF_00F0) begin errors++; $display("FAIL rc_wdata got=%h exp=ffff00f0", wd_seen); end
        old_val = 32'h0000_000F;
        run_op(3'b111, 12'h304, 5'h05, 32'hFFFF_FFFF, 50);
        checks++; if (wes != 1) begin errors++; $display("FAIL rci_we_count got=%0d exp=1", wes); end
        checks++; if (wd_seen !== 32'h0000_000A) begin errors++; $display("FAIL rci_wdata got=%h exp=0000000a", wd_seen); end
        checks++; if (done_ill !== 1'b0) begin errors++; $display("FAIL rci_illegal got=%b exp=0", done_ill); end
        checks++; if (done_rd !== 32'h0000_000F) begin errors++; $display("FAIL rci_rd got=%h exp=0000000f", done_rd); end
        old_val = 32'h0000_0001;
        run_op(3'b110, 12'h305, 5'h10, 32'hFFFF_0000, 50);
        checks++; if (wd_seen !== 32'h0000_0011) begin errors++; $display("FAIL rsi_wdata got=%h exp=00000011", wd_seen); end
        old_val = 32'h8000_0000;
        run_op(3'b101, 12'h306, 5'h1F, 32'h0, 50);
        checks++; if (wd_seen !== 32'h0000_001F) begin errors++; $display("FAIL rwi_wdata got=%h exp=0000001f", wd_seen); end
    endtask

    task automatic test_illegal();
        old_val = 32'h0000_0055;
        run_op(3'b001, 12'hC00, 5'd1, 32'h1, 50);
        checks++; if (lat != 2) begin errors++; $display("FAIL ro_latency got=%0d exp=2", lat); end
        checks++; if (wes != 0) begin errors++; $display("FAIL ro_we_count got=%0d exp=0", wes); end
        checks++; if (done_ill !== 1'b1) begin errors++; $display("FAIL ro_illegal got=%b exp=1", done_ill); end
        checks++; if (done_rd !== 32'h0000_0055) begin errors++; $display("FAIL ro_rd got=%h exp=00000055", done_rd); end
        run_op(3'b010, 12'hC01, 5'd0, 32'h1, 50);
        checks++; if (done_ill !== 1'b0) begin errors++; $display("FAIL ro_read_illegal got=%b exp=0", done_ill); end
        run_op(3'b100, 12'h340, 5'd1, 32'h1, 50);
        checks++; if (lat != 1) begin errors++; $display("FAIL f4_latency got=%0d exp=1", lat); end
        checks++; if (done_ill !== 1'b1) begin errors++; $display("FAIL f4_illegal got=%b exp=1", done_ill); end
        checks++; if (wes != 0) begin errors++; $display("FAIL f4_we_count got=%0d exp=0", wes); end
        run_op(3'b000, 12'h341, 5'd1, 32'h1, 50);
        checks++; if (lat != 1) begin errors++; $display("FAIL f0_latency got=%0d exp=1", lat); end
        checks++; if (done_ill !== 1'b1) begin errors++; $display("FAIL f0_illegal got=%b exp=1", done_ill); end
    endtask

    task automatic test_start_in_done();
        int n;
        old_val = 32'h1;
        @(negedge clk);
        start = 1'b1; func3 = 3'b010; csr_addr = 12'h300; rs1_index = 5'd0; rs1_data = 32'h0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++; if (n != 2) begin errors++; $display("FAIL sd_latency got=%0d exp=2", n); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sd_ignored_busy got=%b exp=0", busy); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_busy_and_reset();
        int wcount;
        ack = 1'b0; old_val = 32'h0;
        @(negedge clk);
        start = 1'b1; func3 = 3'b001; csr_addr = 12'h341; rs1_index = 5'd2; rs1_data = 32'h11;
        @(posedge clk);
        @(negedge clk);
        wcount = 0;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; func3 = 3'b100; csr_addr = 12'h7FF;
            @(posedge clk);
            @(negedge clk);
            if (csr_write_enable) wcount++;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bz_busy[%0d] got=%b exp=1", i, busy); end
            checks++; if (csr_addr_out !== 12'h341) begin errors++; $display("FAIL bz_addr[%0d] got=%h exp=341", i, csr_addr_out); end
        end
        start = 1'b0;
        checks++; if (wcount != 1) begin errors++; $display("FAIL bz_we_count got=%0d exp=1", wcount); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL bz_no_done got=%b exp=0", done); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (csr_write_enable !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", csr_write_enable); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_not_queued got=%b exp=0", busy); end
        ack = 1'b1; old_val = 32'h0000_0300;
        run_op(3'b001, 12'h342, 5'd1, 32'h0000_0ABC, 50);
        checks++; if (lat != 4) begin errors++; $display("FAIL post_rst_latency got=%0d exp=4", lat); end
        checks++; if (wd_seen !== 32'h0000_0ABC) begin errors++; $display("FAIL post_rst_wdata got=%h exp=00000abc", wd_seen); end
        checks++; if (done_rd !== 32'h0000_0300) begin errors++; $display("FAIL post_rst_rd got=%h exp=00000300", done_rd); end
    endtask

    task automatic test_timeout();
        ack = 1'b0; old_val = 32'h0;
`ifdef CSR_TIMEOUT_EN
        run_op(3'b001, 12'h343, 5'd1, 32'h5, 60);
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL to_done got=%b exp=1", got_done); end
        checks++; if (lat != 19) begin errors++; $display("FAIL to_latency got=%0d exp=19", lat); end
        checks++; if (done_ill !== 1'b1) begin errors++; $display("FAIL to_illegal got=%b exp=1", done_ill); end
        ack = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL to_late_ack busy=%b done=%b exp=0/0", busy, done); end
`else
        run_op(3'b001, 12'h343, 5'd1, 32'h5, 100);
        checks++; if (got_done !== 1'b0) begin errors++; $display("FAIL nto_done got=%b exp=0", got_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nto_busy got=%b exp=1", busy); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
`endif
        ack = 1'b1;
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_set_clear();
        test_illegal();
        test_start_in_done();
        test_busy_and_reset();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
